matrix_frame_streamer: RTL and testbench

//   Parametrised successor to the combinational matrix composer. At frame_start it

---
 rtl/matrix_frame_streamer.sv | 187 ++++++++++++++++++
 tb/tb_matrix_frame_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_streamer.sv
// Snapshots the game state on frame_start and streams the composed LED frame one row per handshake.
// Latency: frame_start -> first row_valid 2 cycles; full frame is ROWS+3 cycles with row_ready high.
// Backpressure: row_data/row_idx/row_valid held until row_ready; optional ball blink via BALL_BLINK_EN.
module matrix_frame_streamer #(
    parameter int COLS       = 16,
    parameter int ROWS       = 12,
    parameter int BRICK_ROWS = 7,
    parameter int BRICK_W    = 2,
    parameter int PLATE_ROW  = 10,
    parameter logic [ROWS*COLS-1:0] GO_PATTERN = {(ROWS*COLS){1'b1}},
    parameter int BLINK_LOG2 = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_start,
    input  logic [COLS-1:0]                     plate_row,
    input  logic [$clog2(ROWS)-1:0]             ball_row,
    input  logic [$clog2(COLS)-1:0]             ball_col,
    input  logic [BRICK_ROWS*COLS/BRICK_W-1:0]  bricks,
    input  logic                                game_over,
    output logic [COLS-1:0]                     row_data,
    output logic [$clog2(ROWS)-1:0]             row_idx,
    output logic                                row_valid,
    input  logic                                row_ready,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int BPR = COLS / BRICK_W;
    localparam int NB  = BRICK_ROWS * BPR;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t          state_q;
    state_t          state_d;

    logic [NB-1:0]   bricks_q;
    logic [COLS-1:0] plate_q;
    logic [RW-1:0]   ball_row_q;
    logic [CW-1:0]   ball_col_q;
    logic            go_q;

    logic [RW-1:0]   comp_idx;
    logic [COLS-1:0] comp_row;
    logic            ball_en;
    logic            last_row;
    logic            take_row;

`ifdef BALL_BLINK_EN
    logic [BLINK_LOG2:0] frame_cnt_q;

    // Counts completed frames; its top bit picks the blink phase of the ball.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (state_q == DONE) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign ball_en = ~frame_cnt_q[BLINK_LOG2];
`else
    logic unused_blink;

    assign unused_blink = ^BLINK_LOG2;
    assign ball_en      = 1'b1;
`endif

    assign last_row = (row_idx == RW'(ROWS - 1));
    assign take_row = row_valid && row_ready;

    // Composes the row about to be presented (row 0 in LOAD, row_idx+1 in STREAM) from the snapshot.
    always_comb begin : compose
        int ri;
        int br;
        int bc;
        comp_idx = (state_q == STREAM) ? row_idx + 1'b1 : '0;
        ri       = int'(comp_idx);
        br       = int'(ball_row_q);
        bc       = int'(ball_col_q);
        comp_row = '0;
        if (go_q) begin
            if (ri < ROWS) begin
                comp_row = GO_PATTERN[(ROWS-1-ri)*COLS +: COLS];
            end
        end else begin
            if (ri < BRICK_ROWS) begin
                for (int c = 0; c < COLS; c++) begin
                    comp_row[c] = bricks_q[ri*BPR + c/BRICK_W];
                end
            end
            if (ri == PLATE_ROW) begin
                comp_row = comp_row | plate_q;
            end
            // Out-of-range ball coordinates draw nothing rather than wrapping.
            if (ball_en && (br == ri) && (br < ROWS) && (bc < COLS)) begin
                comp_row[bc] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; busy covers the load and streaming phases only.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (take_row && last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Snapshot capture and registered row outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bricks_q   <= '0;
            plate_q    <= '0;
            ball_row_q <= '0;
            ball_col_q <= '0;
            go_q       <= 1'b0;
            row_data   <= '0;
            row_idx    <= '0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        bricks_q   <= bricks;
                        plate_q    <= plate_row;
                        ball_row_q <= ball_row;
                        ball_col_q <= ball_col;
                        go_q       <= game_over;
                    end
                end
                LOAD: begin
                    row_data  <= comp_row;
                    row_idx   <= '0;
                    row_valid <= 1'b1;
                end
                STREAM: begin
                    if (take_row) begin
                        if (last_row) begin
                            row_valid <= 1'b0;
                        end else begin
                            row_data <= comp_row;
                            row_idx  <= comp_idx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_frame_streamer.sv
// Directed bench for matrix_frame_streamer: table of frames plus reset-abort and blink sequences.
// Latency: checks first row_valid at cycle 2 and frame_done at cycle ROWS+3 with row_ready high.
// Backpressure: random row_ready frames verify hold-until-accepted and in-order row indices.
module tb_matrix_frame_streamer;

    localparam logic [191:0] GO = {16'hC3A0, 16'hC3A1, 16'hC3A2, 16'hC3A3,
                                   16'hC3A4, 16'hC3A5, 16'hC3A6, 16'hC3A7,
                                   16'hC3A8, 16'hC3A9, 16'hC3AA, 16'hC3AB};

    typedef struct {
        logic [55:0]       bricks;
        logic [15:0]       plate;
        logic [3:0]        ball_row;
        logic [3:0]        ball_col;
        logic              go;
        bit                rnd;
        logic [11:0][15:0] exp_rows;
        int                exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [15:0] plate_row;
    logic [3:0]  ball_row;
    logic [3:0]  ball_col;
    logic [55:0] bricks;
    logic        game_over;
    logic [15:0] row_data;
    logic [3:0]  row_idx;
    logic        row_valid;
    logic        row_ready;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    vec_t vecs[6];

    matrix_frame_streamer #(
        .COLS(16), .ROWS(12), .BRICK_ROWS(7), .BRICK_W(2), .PLATE_ROW(10),
        .GO_PATTERN(GO), .BLINK_LOG2(3)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .plate_row(plate_row),
        .ball_row(ball_row), .ball_col(ball_col), .bricks(bricks), .game_over(game_over),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [55:0] b, input logic [15:0] p, input logic [3:0] br,
                                input logic [3:0] bc, input logic g, input bit r, input int d);
        vec_t v;
        v.bricks   = b;
        v.plate    = p;
        v.ball_row = br;
        v.ball_col = bc;
        v.go       = g;
        v.rnd      = r;
        v.exp_rows = '0;
        v.exp_done = d;
        return v;
    endfunction

    // Runs one frame starting and ending at a falling edge; perturbs inputs mid-frame.
    task automatic run_frame(input vec_t v, input string tag);
        int          cyc;
        int          done_cyc;
        int          exp_idx;
        int          stab_err;
        logic        prev_hold;
        logic [15:0] prev_dat;
        logic [3:0]  prev_idx;
        bit          rdy;
        bricks      = v.bricks;
        plate_row   = v.plate;
        ball_row    = v.ball_row;
        ball_col    = v.ball_col;
        game_over   = v.go;
        row_ready   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cyc       = 1;
        done_cyc  = 0;
        exp_idx   = 0;
        stab_err  = 0;
        prev_hold = 1'b0;
        prev_dat  = '0;
        prev_idx  = '0;
        while (cyc < 80 && done_cyc == 0) begin
            if (prev_hold && (row_data !== prev_dat || row_idx !== prev_idx)) stab_err++;
            if (frame_done) done_cyc = cyc;
            if (cyc == 1) check({tag, " busy_c1"}, busy, 1'b1);
            if (cyc == 1) check({tag, " valid_c1"}, row_valid, 1'b0);
            if (cyc == 2) check({tag, " valid_c2"}, row_valid, 1'b1);
            if (cyc == 5) begin
                bricks      = ~v.bricks;
                plate_row   = ~v.plate;
                ball_row    = v.ball_row + 4'd1;
                game_over   = ~v.go;
                frame_start = 1'b1;
            end
            if (cyc == 6) frame_start = 1'b0;
            rdy       = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            row_ready = rdy;
            if (row_valid && rdy) begin
                check($sformatf("%s idx%0d", tag, exp_idx), row_idx, exp_idx);
                if (exp_idx < 12)
                    check($sformatf("%s row%0d", tag, exp_idx), row_data, v.exp_rows[exp_idx]);
                exp_idx++;
            end
            prev_hold = row_valid && !rdy;
            prev_dat  = row_data;
            prev_idx  = row_idx;
            @(negedge clk);
            cyc++;
        end
        row_ready = 1'b0;
        check({tag, " rows_accepted"}, exp_idx, 12);
        check({tag, " hold_stable_errs"}, stab_err, 0);
        if (v.exp_done != 0) check({tag, " done_cycle"}, done_cyc, v.exp_done);
        else                 check({tag, " done_seen"}, done_cyc != 0, 1'b1);
        check({tag, " busy_after"}, busy, 1'b0);
        check({tag, " valid_after"}, row_valid, 1'b0);
        check({tag, " done_pulse_1cyc"}, frame_done, 1'b0);
    endtask

    initial begin
        vec_t v;
        int   n;
        int   seen;
        rst = 1'b1; frame_start = 1'b0; plate_row = '0; ball_row = '0; ball_col = '0;
        bricks = '0; game_over = 1'b0; row_ready = 1'b0;

        // Frame table: {bricks, plate, ball, game_over, random ready, done cycle} + expected rows.
        vecs[0] = mk({56{1'b1}}, 16'h0FF0, 4'd9, 4'd3, 1'b0, 1'b0, 15);
        for (int r = 0; r < 7; r++) vecs[0].exp_rows[r] = 16'hFFFF;
        vecs[0].exp_rows[9]  = 16'h0008;
        vecs[0].exp_rows[10] = 16'h0FF0;
        vecs[1] = mk(56'h200, 16'h00F0, 4'd10, 4'd4, 1'b0, 1'b1, 0);
        vecs[1].exp_rows[1]  = 16'h000C;
        vecs[1].exp_rows[10] = 16'h00F0;
        vecs[2] = mk(56'h0, 16'h0000, 4'd12, 4'd0, 1'b0, 1'b0, 15);
        vecs[3] = mk(56'h0, 16'h0000, 4'd0, 4'd15, 1'b0, 1'b0, 15);
        vecs[3].exp_rows[0] = 16'h8000;
        vecs[4] = mk({56{1'b1}}, 16'hFFFF, 4'd3, 4'd3, 1'b1, 1'b1, 0);
        for (int r = 0; r < 12; r++) vecs[4].exp_rows[r] = 16'hC3A0 + 16'(r);
        vecs[5] = mk(56'h80_0000_0000_0001, 16'h0000, 4'd6, 4'd0, 1'b0, 1'b0, 15);
        vecs[5].exp_rows[0] = 16'h0003;
        vecs[5].exp_rows[6] = 16'hC001;

        repeat (3) @(negedge clk);
        check("rst_valid", row_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_data", row_data, 16'h0);
        check("rst_idx", row_idx, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        // Reset while streaming row 5 aborts the frame without a frame_done pulse.
        bricks = {56{1'b1}}; plate_row = 16'h0FF0; ball_row = 4'd9; ball_col = 4'd3;
        game_over = 1'b0; row_ready = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (!(row_valid && row_idx == 4'd5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_row5", row_idx, 4'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", row_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_data", row_data, 16'h0);
        check("abort_idx", row_idx, 4'h0);
        check("abort_done", frame_done, 1'b0);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done) seen++;
        end
        check("abort_no_done", seen, 0);
        row_ready = 1'b0;

`ifdef BALL_BLINK_EN
        // Counter restarted by the abort reset: ball visible in frames 0-7, hidden in 8-15.
        for (int f = 0; f < 16; f++) begin
            v = mk(56'h0, 16'h0000, 4'd3, 4'd5, 1'b0, 1'b0, 15);
            v.exp_rows[3] = (f < 8) ? 16'h0020 : 16'h0000;
            run_frame(v, $sformatf("blink%0d", f));
        end
`else
        v = vecs[5];
        run_frame(v, "recover");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
